// File: rtl/pingpong_capture_sched.sv
// Ping-pong capture scheduler: frames the ADC/DDC valid stream into two BRAM buffers.
// Build option: define CAPTURE_ABORT_EN to let sinc restart a frame in progress.

module pingpong_capture_sched #(
  parameter int N_SAMPLES = 1024,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              sinc,
  input  logic              valid,
  input  logic [31:0]       datos_i,
  input  logic              rd_done_1,
  input  logic              rd_done_2,
  output logic              en_1,
  output logic              en_2,
  output logic [3:0]        wrt_en,
  output logic [31:0]       addr,
  output logic [31:0]       datos_o,
  output logic              rdy_1,
  output logic              rdy_2,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  // state     | meaning
  // IDLE      | capture disarmed
  // WAIT_SINC | armed, waiting for a frame start
  // CAPTURE   | writing samples into the active buffer

  localparam int CW = $clog2(N_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SINC = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              act_q, act_d;
  logic [CW-1:0]     cnt_q, cnt_d, wr_cnt;
  logic              en1_q, en1_d, en2_q, en2_d, wr_q, wr_d;
  logic [31:0]       addr_q, addr_d, dat_q, dat_d;
  logic [1:0]        rdy_q, rdy_d;
  logic              ovr_q, ovr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              done_q, done_d, done_buf_q, done_buf_d;
  logic              act_rdy, abort, wr_fire, last_wr;

  assign act_rdy = rdy_q[act_q];

`ifdef CAPTURE_ABORT_EN
  assign abort = (state_q == CAPTURE) && sinc;
`else
  assign abort = 1'b0;
`endif

  assign wr_fire = (state_q == CAPTURE) && valid;
  assign wr_cnt  = abort ? '0 : cnt_q;
  assign last_wr = wr_fire && !abort && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arm) state_d = WAIT_SINC;
      WAIT_SINC: begin
        if (!arm)                 state_d = IDLE;
        else if (sinc && !act_rdy) state_d = CAPTURE;
      end
      CAPTURE:   if (last_wr) state_d = WAIT_SINC;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    act_d      = act_q;
    cnt_d      = cnt_q;
    en1_d      = 1'b0;
    en2_d      = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    dat_d      = dat_q;
    rdy_d      = rdy_q;
    ovr_d      = ovr_q;
    fcnt_d     = fcnt_q;
    done_d     = 1'b0;
    done_buf_d = done_buf_q;

    if (rd_done_1) rdy_d[0] = 1'b0;
    if (rd_done_2) rdy_d[1] = 1'b0;

    // Buffer is flagged the cycle after its last write lands in BRAM.
    if (done_q) begin
      rdy_d[done_buf_q] = 1'b1;
      fcnt_d            = fcnt_q + 1'b1;
    end

    if (state_q == WAIT_SINC && arm && sinc) begin
      if (act_rdy) ovr_d = 1'b1;
      else         cnt_d = '0;
    end

    if (wr_fire) begin
      en1_d  = !act_q;
      en2_d  = act_q;
      wr_d   = 1'b1;
      addr_d = {{(30-CW){1'b0}}, wr_cnt, 2'b00};
      dat_d  = datos_i;
      if (last_wr) begin
        act_d      = !act_q;
        cnt_d      = '0;
        done_d     = 1'b1;
        done_buf_d = act_q;
      end else begin
        cnt_d = wr_cnt + 1'b1;
      end
    end else if (abort) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q      <= 1'b0;
      cnt_q      <= '0;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      rdy_q      <= '0;
      ovr_q      <= 1'b0;
      fcnt_q     <= '0;
      done_q     <= 1'b0;
      done_buf_q <= 1'b0;
    end else begin
      act_q      <= act_d;
      cnt_q      <= cnt_d;
      en1_q      <= en1_d;
      en2_q      <= en2_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      rdy_q      <= rdy_d;
      ovr_q      <= ovr_d;
      fcnt_q     <= fcnt_d;
      done_q     <= done_d;
      done_buf_q <= done_buf_d;
    end
  end

  assign en_1      = en1_q;
  assign en_2      = en2_q;
  assign wrt_en    = {4{wr_q}};
  assign addr      = addr_q;
  assign datos_o   = dat_q;
  assign rdy_1     = rdy_q[0];
  assign rdy_2     = rdy_q[1];
  assign overrun   = ovr_q;
  assign frame_cnt = fcnt_q;
  assign busy      = (state_q == CAPTURE);

endmodule

// File: tb/tb_pingpong_capture_sched.sv
// Testbench for pingpong_capture_sched: directed scenarios plus a randomized run
// against a frame-level reference model.

module tb_pingpong_capture_sched;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int W  = 74 + FW;

  logic          clk = 1'b0;
  logic          rst, arm, sinc, valid, rd_done_1, rd_done_2;
  logic [31:0]   datos_i;
  logic          en_1, en_2, rdy_1, rdy_2, overrun, busy;
  logic [3:0]    wrt_en;
  logic [31:0]   addr, datos_o;
  logic [FW-1:0] frame_cnt;

  int total    = 0;
  int pass_cnt = 0;

  logic [1:0]  q_en[$];
  logic [31:0] q_addr[$];
  logic [31:0] q_dat[$];

  // Reference model: mode 0 = disarmed, 1 = waiting for frame start, 2 = capturing.
  int            m_mode, m_act, m_cnt, m_pbuf;
  logic          m_pend, m_wr, m_ovr;
  logic [1:0]    m_en, m_rdy;
  logic [31:0]   m_addr, m_dat;
  logic [FW-1:0] m_fcnt;

  pingpong_capture_sched #(.N_SAMPLES(N), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sinc(sinc), .valid(valid), .datos_i(datos_i),
    .rd_done_1(rd_done_1), .rd_done_2(rd_done_2), .en_1(en_1), .en_2(en_2),
    .wrt_en(wrt_en), .addr(addr), .datos_o(datos_o), .rdy_1(rdy_1), .rdy_2(rdy_2),
    .overrun(overrun), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wrt_en != 4'h0) begin
      q_en.push_back({en_2, en_1});
      q_addr.push_back(addr);
      q_dat.push_back(datos_o);
    end
  end

  function automatic logic [W-1:0] dut_vec();
    return {en_2, en_1, wrt_en, addr, datos_o, rdy_2, rdy_1, overrun, frame_cnt, busy};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    q_en.delete();
    q_addr.delete();
    q_dat.delete();
  endtask

  task automatic run_frame(input int n, input int gap, input logic [31:0] base,
                           output logic [1:0] rdy_last);
    rdy_last = 2'b11;
    sinc = 1'b1;
    cyc();
    sinc = 1'b0;
    for (int k = 0; k < n; k++) begin
      valid   = 1'b1;
      datos_i = base + k;
      cyc();
      valid = 1'b0;
      if (k == n - 1) rdy_last = {rdy_2, rdy_1};
      repeat (gap) cyc();
    end
    cyc();
  endtask

  task automatic model_reset();
    m_mode = 0; m_act = 0; m_cnt = 0; m_pbuf = 0;
    m_pend = 1'b0; m_wr = 1'b0; m_ovr = 1'b0;
    m_en = 2'b00; m_rdy = 2'b00; m_addr = '0; m_dat = '0; m_fcnt = '0;
  endtask

  // Predicts the outputs after the coming clock edge from the inputs now driven.
  task automatic model_step();
    logic [1:0] old_rdy;
    old_rdy = m_rdy;
    m_en = 2'b00;
    m_wr = 1'b0;
    if (rd_done_1 && old_rdy[0]) m_rdy[0] = 1'b0;
    if (rd_done_2 && old_rdy[1]) m_rdy[1] = 1'b0;
    if (m_pend) begin
      m_rdy[m_pbuf] = 1'b1;
      m_fcnt = m_fcnt + 1'b1;
      m_pend = 1'b0;
    end
    case (m_mode)
      0: if (arm) m_mode = 1;
      1: begin
        if (!arm) m_mode = 0;
        else if (sinc) begin
          if (old_rdy[m_act]) m_ovr = 1'b1;
          else begin m_mode = 2; m_cnt = 0; end
        end
      end
      default: begin
`ifdef CAPTURE_ABORT_EN
        if (sinc) m_cnt = 0;
`endif
        if (valid) begin
          m_en[m_act] = 1'b1;
          m_wr   = 1'b1;
          m_addr = 32'(m_cnt * 4);
          m_dat  = datos_i;
          if (m_cnt == N - 1) begin
            m_pend = 1'b1; m_pbuf = m_act; m_act = 1 - m_act; m_cnt = 0; m_mode = 1;
          end else begin
            m_cnt++;
          end
        end
      end
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; sinc = 1'b0; valid = 1'b0;
    rd_done_1 = 1'b0; rd_done_2 = 1'b0; datos_i = '0;
    #3;
    total++;
    if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
    else pass_cnt++;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    clear_q();
    sinc = 1'b1; valid = 1'b1; datos_i = 32'h55;
    cyc(); cyc();
    sinc = 1'b0; valid = 1'b0;
    cyc();
    total++;
    if ({q_en.size() != 0, busy} !== 2'b00)
      $display("FAIL idle_ignores_sinc: writes %0d busy %b want 0 0", q_en.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [1:0] rl;
    arm = 1'b1;
    cyc();
    clear_q();
    run_frame(N, 0, 32'd0, rl);
    total++;
    if (q_en.size() != N) $display("FAIL basic_write_count: got %0d want %0d", q_en.size(), N);
    else pass_cnt++;
    for (int k = 0; k < q_en.size(); k++) begin
      total++;
      if ({q_en[k], q_addr[k], q_dat[k]} !== {2'b01, 32'(k * 4), 32'(k)})
        $display("FAIL basic_write[%0d]: got en %b addr %0d dat %0d want 01 %0d %0d",
                 k, q_en[k], q_addr[k], q_dat[k], k * 4, k);
      else pass_cnt++;
    end
    total++;
    if (rl !== 2'b00) $display("FAIL basic_rdy_during_last: got %b want 00", rl);
    else pass_cnt++;
    total++;
    if ({rdy_2, rdy_1, frame_cnt, busy} !== {2'b01, FW'(1), 1'b0})
      $display("FAIL basic_done: got rdy %b%b fcnt %0d busy %b want 01 1 0",
               rdy_2, rdy_1, frame_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_pingpong();
    logic [1:0] rl;
    clear_q();
    run_frame(N, 0, 32'd100, rl);
    total++;
    if (q_en.size() != N) $display("FAIL pp_write_count: got %0d want %0d", q_en.size(), N);
    else pass_cnt++;
    for (int k = 0; k < q_en.size(); k++) begin
      total++;
      if ({q_en[k], q_addr[k], q_dat[k]} !== {2'b10, 32'(k * 4), 32'(100 + k)})
        $display("FAIL pp_write[%0d]: got en %b addr %0d dat %0d want 10 %0d %0d",
                 k, q_en[k], q_addr[k], q_dat[k], k * 4, 100 + k);
      else pass_cnt++;
    end
    total++;
    if ({rdy_2, rdy_1, overrun, frame_cnt} !== {2'b11, 1'b0, FW'(2)})
      $display("FAIL pp_both_ready: got rdy %b%b ovr %b fcnt %0d want 11 0 2",
               rdy_2, rdy_1, overrun, frame_cnt);
    else pass_cnt++;
    clear_q();
    run_frame(N, 0, 32'd200, rl);
    total++;
    if ({q_en.size() != 0, overrun, frame_cnt, busy} !== {1'b0, 1'b1, FW'(2), 1'b0})
      $display("FAIL pp_overrun: got writes %0d ovr %b fcnt %0d busy %b want 0 1 2 0",
               q_en.size(), overrun, frame_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_release();
    logic [1:0] rl;
    rd_done_1 = 1'b1;
    cyc();
    rd_done_1 = 1'b0;
    total++;
    if ({rdy_2, rdy_1} !== 2'b10) $display("FAIL release_1: got %b%b want 10", rdy_2, rdy_1);
    else pass_cnt++;
    clear_q();
    run_frame(N, 0, 32'd300, rl);
    total++;
    if (q_en.size() != N || q_en[0] !== 2'b01 || q_en[N-1] !== 2'b01 || q_addr[N-1] !== 32'((N - 1) * 4))
      $display("FAIL release_recapture: got %0d writes, first en %b want %0d writes en 01",
               q_en.size(), (q_en.size() > 0) ? q_en[0] : 2'b00, N);
    else pass_cnt++;
    total++;
    if ({rdy_2, rdy_1, overrun, frame_cnt} !== {2'b11, 1'b1, FW'(3)})
      $display("FAIL release_after: got rdy %b%b ovr %b fcnt %0d want 11 1 3",
               rdy_2, rdy_1, overrun, frame_cnt);
    else pass_cnt++;
    rd_done_1 = 1'b1; rd_done_2 = 1'b1;
    cyc();
    rd_done_1 = 1'b0; rd_done_2 = 1'b0;
    total++;
    if ({rdy_2, rdy_1} !== 2'b00) $display("FAIL release_both: got %b%b want 00", rdy_2, rdy_1);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    logic [1:0] rl;
    clear_q();
    run_frame(N + 2, 2, 32'd400, rl);
    total++;
    if (q_en.size() != N) $display("FAIL gap_write_count: got %0d want %0d", q_en.size(), N);
    else pass_cnt++;
    for (int k = 0; k < q_en.size(); k++) begin
      total++;
      if ({q_en[k], q_addr[k], q_dat[k]} !== {2'b10, 32'(k * 4), 32'(400 + k)})
        $display("FAIL gap_write[%0d]: got en %b addr %0d dat %0d want 10 %0d %0d",
                 k, q_en[k], q_addr[k], q_dat[k], k * 4, 400 + k);
      else pass_cnt++;
    end
    total++;
    if ({rdy_2, rdy_1, frame_cnt} !== {2'b10, FW'(4)})
      $display("FAIL gap_done: got rdy %b%b fcnt %0d want 10 4", rdy_2, rdy_1, frame_cnt);
    else pass_cnt++;
    rd_done_2 = 1'b1;
    cyc();
    rd_done_2 = 1'b0;
  endtask

  task automatic test_arm_drop();
    clear_q();
    sinc = 1'b1;
    cyc();
    sinc = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 4) arm = 1'b0;
      valid = 1'b1; datos_i = 500 + k;
      cyc();
      valid = 1'b0;
      cyc();
    end
    cyc();
    sinc = 1'b1; valid = 1'b1;
    cyc();
    sinc = 1'b0;
    cyc(); cyc();
    valid = 1'b0;
    total++;
    if (q_en.size() != N || q_addr[N-1] !== 32'((N - 1) * 4) || q_en[N-1] !== 2'b01)
      $display("FAIL armdrop_frame: got %0d writes want %0d", q_en.size(), N);
    else pass_cnt++;
    total++;
    if ({busy, rdy_1, frame_cnt} !== {1'b0, 1'b1, FW'(5)})
      $display("FAIL armdrop_idle: got busy %b rdy1 %b fcnt %0d want 0 1 5", busy, rdy_1, frame_cnt);
    else pass_cnt++;
    arm = 1'b1;
    cyc();
    sinc = 1'b1;
    cyc();
    sinc = 1'b0;
    valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      datos_i = 550 + k;
      cyc();
    end
    total++;
    if ({en_2, busy} !== 2'b11) $display("FAIL midframe_active: got en2 %b busy %b want 1 1", en_2, busy);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (dut_vec() !== '0) $display("FAIL async_reset_outputs: got %h want 0", dut_vec());
    else pass_cnt++;
    cyc();
    valid = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    clear_q();
    sinc = 1'b1;
    cyc();
    sinc = 1'b0;
    for (int k = 0; k < N + 5; k++) begin
      valid = 1'b1; datos_i = 600 + k;
      if (k == 5) sinc = 1'b1;
      cyc();
      sinc = 1'b0; valid = 1'b0;
      if (k == 5) begin
        total++;
        if (frame_cnt !== FW'(0)) $display("FAIL abort_fcnt_hold: got %0d want 0", frame_cnt);
        else pass_cnt++;
      end
    end
    cyc(); cyc();
`ifdef CAPTURE_ABORT_EN
    total++;
    if (q_en.size() != N + 5 || q_addr[5] !== 32'd0 || q_dat[5] !== 32'd605 ||
        q_addr[N+4] !== 32'((N - 1) * 4) || q_en[N+4] !== 2'b01)
      $display("FAIL abort_restart: got %0d writes, 6th addr %0d want %0d writes, 6th addr 0",
               q_en.size(), (q_addr.size() > 5) ? q_addr[5] : 32'hFFFF, N + 5);
    else pass_cnt++;
`else
    total++;
    if (q_en.size() != N || q_addr[5] !== 32'd20 || q_addr[N-1] !== 32'((N - 1) * 4))
      $display("FAIL sinc_ignored: got %0d writes, 6th addr %0d want %0d writes, 6th addr 20",
               q_en.size(), (q_addr.size() > 5) ? q_addr[5] : 32'hFFFF, N);
    else pass_cnt++;
`endif
    total++;
    if ({rdy_2, rdy_1, frame_cnt} !== {2'b01, FW'(1)})
      $display("FAIL abort_done: got rdy %b%b fcnt %0d want 01 1", rdy_2, rdy_1, frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_fcnt_wrap();
    logic [1:0] rl;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    arm = 1'b1;
    cyc();
    for (int f = 0; f < 8; f++) begin
      clear_q();
      run_frame(N, 0, 32'(f * 16), rl);
      total++;
      if (q_en.size() != N || q_en[0] !== ((f % 2 == 0) ? 2'b01 : 2'b10) || frame_cnt !== FW'((f + 1) % 8))
        $display("FAIL wrap_frame[%0d]: got %0d writes fcnt %0d want %0d writes fcnt %0d",
                 f, q_en.size(), frame_cnt, N, (f + 1) % 8);
      else pass_cnt++;
      rd_done_1 = 1'b1; rd_done_2 = 1'b1;
      cyc();
      rd_done_1 = 1'b0; rd_done_2 = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got, exp;
    int nprint;
    nprint = 0;
    rst = 1'b1; arm = 1'b0; sinc = 1'b0; valid = 1'b0; rd_done_1 = 1'b0; rd_done_2 = 1'b0;
    model_reset();
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      arm       = ($urandom_range(0, 19) != 0);
      sinc      = ($urandom_range(0, 14) == 0);
      valid     = ($urandom_range(0, 9) < 7);
      rd_done_1 = ($urandom_range(0, 9) == 0);
      rd_done_2 = ($urandom_range(0, 9) == 0);
      datos_i   = $urandom;
      model_step();
      cyc();
      got = dut_vec();
      exp = {m_en[1], m_en[0], {4{m_wr}}, m_addr, m_dat, m_rdy[1], m_rdy[0], m_ovr, m_fcnt, m_mode == 2};
      total++;
      if (got !== exp) begin
        if (nprint < 20) $display("FAIL random_cycle_%0d: got %h want %h", c, got, exp);
        nprint++;
      end else pass_cnt++;
      total++;
      if ((en_1 & en_2) !== 1'b0) begin
        if (nprint < 20) $display("FAIL random_en_exclusive_%0d: got en %b%b want not 11", c, en_2, en_1);
        nprint++;
      end else pass_cnt++;
    end
    sinc = 1'b0; valid = 1'b0; rd_done_1 = 1'b0; rd_done_2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pingpong();
    test_release();
    test_gapped();
    test_arm_drop();
    test_abort();
    test_fcnt_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pingpong_capture_sched.md
Name: pingpong_capture_sched

Overview:
- Sequences receiver sample capture into two ping-pong BRAM buffers (BRAM 1, BRAM 2). Each buffer holds one frame per sinc pulse.
- Gates BRAM write enables and generates write addresses.
- Flags each buffer ready-to-read when full, and holds it until the PS releases it via rd_done.
- Sits between the ADC/DDC valid stream and the BRAM write ports. Replaces free-running buffer toggling with an explicit frame scheduler.

Parameters:
N_SAMPLES, 1024, 32-bit words captured per frame/buffer (>=2)
FCNT_W, 16, width of frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
arm  in  1  level; 1 = capture enabled
sinc  in  1  single-cycle frame start pulse from transmitter timing
valid  in  1  sample strobe, qualifies datos_i
datos_i  in  32  input sample
rd_done_1  in  1  single-cycle pulse; PS finished reading BRAM 1
rd_done_2  in  1  single-cycle pulse; PS finished reading BRAM 2
en_1  out  1  BRAM 1 port enable
en_2  out  1  BRAM 2 port enable
wrt_en  out  4  byte write enable (4'hF on write, else 4'h0)
addr  out  32  byte address, word index * 4
datos_o  out  32  registered copy of datos_i, aligned with wrt_en
rdy_1  out  1  BRAM 1 full, awaiting read
rdy_2  out  1  BRAM 2 full, awaiting read
overrun  out  1  sticky: frame dropped because target buffer not released
frame_cnt  out  FCNT_W  completed frames, wraps at 2^FCNT_W
busy  out  1  1 while in CAPTURE

Behaviour:
- Reset (async, any state): state=IDLE, active buffer=1, word count=0. All outputs 0.
- FSM states are IDLE, WAIT_SINC, CAPTURE.
- IDLE:
  - arm=1 -> WAIT_SINC.
  - sinc/valid are ignored.
- WAIT_SINC:
  - arm=0 -> IDLE.
  - sinc=1 with rdy of active buffer = 0 -> CAPTURE, count=0.
  - sinc=1 with rdy of active buffer = 1 -> frame dropped, overrun<=1, stay in WAIT_SINC.
  - valid is ignored.
- CAPTURE:
  - busy=1.
  - Each valid=1 cycle produces one write, registered with 1-cycle latency. Next cycle: en_x=1 for the active buffer only, wrt_en=4'hF, addr=count*4, datos_o=datos_i. Then count increments.
  - Cycles with valid=0: en_1=en_2=0, wrt_en=0. addr and datos_o hold.
  - The write with count=N_SAMPLES-1 completes the frame. In the same cycle as that write's outputs: rdy_x<=1 for the active buffer, active toggles, frame_cnt+1, count<=0, state -> WAIT_SINC. rdy_x is visible one cycle after the last write.
  - arm=0 during CAPTURE: the frame completes normally, then WAIT_SINC, then IDLE.
  - sinc during CAPTURE: ignored (see optional feature).
- rd_done_x:
  - Clears rdy_x on the next edge.
  - Ignored if rdy_x=0.
  - rd_done_1 and rd_done_2 in the same cycle are both honoured.
  - A buffer is never set and released in the same cycle: a buffer is only written when its rdy=0.
- Last addr written = (N_SAMPLES-1)*4. Count uses clog2(N_SAMPLES) bits. addr is zero-extended to 32.
- overrun clears only on reset.
- frame_cnt wraps from 2^FCNT_W-1 to 0.
- en_1 and en_2 are never both 1.

Optional Feature:
CAPTURE_ABORT_EN
- Defined: sinc=1 in CAPTURE aborts the current frame. That buffer's rdy stays 0, partial data is discarded, and the active buffer is unchanged. count<=0 and capture restarts into the same buffer from addr 0. A valid in the same cycle as the aborting sinc is written at addr 0. frame_cnt is not incremented for the aborted frame.
- Undefined: sinc in CAPTURE is ignored.

Test Plan:
- Basic frame (N_SAMPLES=8): rst, arm=1, sinc, 8 valids back-to-back, datos_i=0..7 -> en_1 pulses 8 cycles, addr 0,4,...,28, datos_o 0..7, rdy_1=1 one cycle after last write, frame_cnt=1, en_2 never 1.
- Ping-pong: two frames, no rd_done -> frame 2 writes BRAM 2 only, rdy_1=rdy_2=1, frame_cnt=2. Third sinc -> overrun=1, no writes, frame_cnt stays 2.
- Release: after the above, pulse rd_done_1 -> rdy_1=0 next cycle. Next sinc captures into BRAM 1 (active toggled back), overrun stays 1.
- Gapped valid: valid every 3rd cycle -> writes only on valid cycles, addr increments by 4 per write, frame ends after exactly 8 writes.
- Arm drop / reset mid-frame: arm=0 after 4 writes -> frame completes (8 writes), then IDLE and further sinc ignored. Async rst mid-frame -> all outputs 0 immediately, rdy_1=rdy_2=0.
- CAPTURE_ABORT_EN: sinc after 5 writes -> next write at addr 0 to the same buffer, frame_cnt unchanged. Without the macro, the 6th write lands at addr 20.
